// File: rtl/noc_out_port_sched.sv
// Round-robin output-port scheduler with one registered output stage.
// Optional packet locking (contiguous head..tail from one source) under NOC_SCHED_PKT_LOCK_EN.
module noc_out_port_sched #(
  parameter int unsigned NUM_IN = 5,
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned SRC_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_tail,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_tail,
  output logic [SRC_W-1:0]        out_src
);

  localparam logic [SRC_W-1:0] LastIdx = SRC_W'(NUM_IN - 1);

  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] cand, cand_nxt, hi_idx, lo_idx;
  logic             found, found_hi;
  logic             free, xfer;
  logic [WIDTH-1:0] sel_data;
  logic             sel_tail;

`ifdef NOC_SCHED_PKT_LOCK_EN
  typedef enum logic [0:0] {StArb, StLock} state_e;
  state_e           state_q, state_d;
  logic [SRC_W-1:0] own_q, own_d;
`endif

  assign free = !out_valid || out_ready;

  // Descending scan: last hit is the lowest index; hi_idx only counts ports at or above ptr.
  always_comb begin
    found    = 1'b0;
    found_hi = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        found  = 1'b1;
        lo_idx = SRC_W'(i);
        if (SRC_W'(i) >= ptr_q) begin
          found_hi = 1'b1;
          hi_idx   = SRC_W'(i);
        end
      end
    end
    cand = found_hi ? hi_idx : lo_idx;
`ifdef NOC_SCHED_PKT_LOCK_EN
    // While locked only the owner may be granted, even if it is idle.
    if (state_q == StLock) begin
      cand  = own_q;
      found = in_valid[own_q];
    end
`endif
  end

  assign xfer     = found && free && !reset;
  assign cand_nxt = (cand == LastIdx) ? '0 : cand + 1'b1;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    sel_tail = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SRC_W'(i) == cand) begin
        in_ready[i] = xfer;
        sel_data    = in_data[i*WIDTH +: WIDTH];
        sel_tail    = in_tail[i];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef NOC_SCHED_PKT_LOCK_EN
    state_d = state_q;
    own_d   = own_q;
    if (xfer) begin
      if (sel_tail) begin
        ptr_d   = cand_nxt;
        state_d = StArb;
      end else if (state_q == StArb) begin
        state_d = StLock;
        own_d   = cand;
      end
    end
`else
    if (xfer) begin
      ptr_d = cand_nxt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tail  <= 1'b0;
      out_src   <= '0;
`ifdef NOC_SCHED_PKT_LOCK_EN
      state_q   <= StArb;
      own_q     <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
`ifdef NOC_SCHED_PKT_LOCK_EN
      state_q <= state_d;
      own_q   <= own_d;
`endif
      if (free) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= sel_data;
          out_tail <= sel_tail;
          out_src  <= cand;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_out_port_sched.sv
// Scoreboard bench for noc_out_port_sched: stimulus pushes expected flits, a negedge
// monitor pops and compares each flit as it leaves the output register.
module tb_noc_out_port_sched;
  localparam int N = 5;
  localparam int W = 3;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   in_valid, in_ready, in_tail;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready, out_tail;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_src;

  int tests = 0;
  int fails = 0;
  logic [S+W:0] exp_q[$];
  logic [S+W:0] mon_exp;
  int seq[$];
  int n1;

  always #5 clk = ~clk;

  noc_out_port_sched #(.NUM_IN(N), .WIDTH(W), .SRC_W(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tail  (in_tail),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tail (out_tail),
    .out_src  (out_src)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input int p, input logic v, input logic [W-1:0] d, input logic t);
    in_valid[p]       = v;
    in_data[p*W +: W] = d;
    in_tail[p]        = t;
  endtask

  task automatic clr();
    in_valid = '0;
    in_data  = '0;
    in_tail  = '0;
  endtask

  task automatic push(input int src, input int data, input logic tail);
    exp_q.push_back({S'(src), W'(data), tail});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    step();
    reset = 1'b0;
  endtask

  // Monitor: every flit leaving the output register must match the head of the queue.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL flit_unexpected: got src=%0d data=%0h tail=%0b, expected none",
                 out_src, out_data, out_tail);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_src, out_data, out_tail} !== mon_exp) begin
          fails++;
          $display("FAIL flit: got src=%0d data=%0h tail=%0b, expected src=%0d data=%0h tail=%0b",
                   out_src, out_data, out_tail, mon_exp[S+W:W+1], mon_exp[W:1], mon_exp[0]);
        end
      end
    end
  end

  initial begin
    clr();
    out_ready = 1'b1;

    // Reset: no grant during the reset cycle even with all ports requesting.
    step();
    in_valid = '1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tail", out_tail, 0);
    check("rst_out_src", out_src, 0);
    clr();
    reset = 1'b0;

    // Ports 0 and 3: port 0 first, then 3, leaving ptr at 4.
    setp(0, 1, 3'b101, 1);
    setp(3, 1, 3'b010, 1);
    @(negedge clk);
    check("a_rdy0", in_ready, 5'b00001);
    push(0, 5, 1);
    step();
    check("a_src0", out_src, 0);
    check("a_data0", out_data, 5);
    setp(0, 0, 0, 0);
    @(negedge clk);
    check("a_rdy3", in_ready, 5'b01000);
    push(3, 2, 1);
    step();
    setp(3, 0, 0, 0);
    setp(0, 1, 1, 1);
    setp(4, 1, 4, 1);
    @(negedge clk);
    check("a_ptr4", in_ready, 5'b10000);
    push(4, 4, 1);
    step();
    clr();
    step();
    step();

    // All ports valid, single-flit packets: strict rotation 0..4 twice.
    for (int p = 0; p < N; p++) setp(p, 1, W'(p + 1), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("b_rdy%0d", k), in_ready, 1 << (k % N));
      push(k % N, (k % N) + 1, 1);
      step();
    end
    clr();
    step();
    step();

    // Backpressure: held flit stays stable, then drain and refill on one edge.
    setp(2, 1, 6, 1);
    @(negedge clk);
    check("c_rdy2", in_ready, 5'b00100);
    push(2, 6, 1);
    step();
    setp(2, 0, 0, 0);
    setp(1, 1, 3, 1);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("c_hold_valid%0d", k), out_valid, 1);
      check($sformatf("c_hold_src%0d", k), out_src, 2);
      check($sformatf("c_hold_data%0d", k), out_data, 6);
      check($sformatf("c_hold_rdy%0d", k), in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("c_refill_rdy", in_ready, 5'b00010);
    push(1, 3, 1);
    step();
    check("c_refill_valid", out_valid, 1);
    check("c_refill_src", out_src, 1);
    check("c_refill_data", out_data, 3);
    clr();
    step();
    step();

    // Port 1 three-flit packet vs port 2 continuously valid.
    do_reset();
`ifdef NOC_SCHED_PKT_LOCK_EN
    seq = '{1, 1, 1, 2};
`else
    seq = '{1, 2, 1, 2, 1};
`endif
    n1 = 0;
    setp(1, 1, 1, 0);
    setp(2, 1, 7, 1);
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      check($sformatf("d_rdy%0d", i), in_ready, 1 << seq[i]);
      if (seq[i] == 1) push(1, n1 + 1, n1 == 2);
      else push(2, 7, 1);
      step();
      if (seq[i] == 1) begin
        n1++;
        if (n1 == 3) setp(1, 0, 0, 0);
        else setp(1, 1, W'(n1 + 1), n1 == 2);
      end
    end
    clr();
    step();
    step();

`ifdef NOC_SCHED_PKT_LOCK_EN
    // Owner idles mid-packet: bubble, port 4 locked out until the tail.
    do_reset();
    setp(1, 1, 1, 0);
    setp(4, 1, 4, 1);
    @(negedge clk);
    check("e_rdy_head", in_ready, 5'b00010);
    push(1, 1, 0);
    step();
    setp(1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("e_idle_rdy%0d", k), in_ready, 0);
      step();
      check($sformatf("e_idle_valid%0d", k), out_valid, 0);
    end
    setp(1, 1, 2, 0);
    @(negedge clk);
    check("e_rdy_body", in_ready, 5'b00010);
    push(1, 2, 0);
    step();
    setp(1, 1, 3, 1);
    @(negedge clk);
    check("e_rdy_tail", in_ready, 5'b00010);
    push(1, 3, 1);
    step();
    setp(1, 0, 0, 0);
    @(negedge clk);
    check("e_rdy_p4", in_ready, 5'b10000);
    push(4, 4, 1);
    step();
    clr();
    step();
    step();
`endif

    // Reset mid-packet on port 2: first grant afterwards restarts from ptr 0.
    do_reset();
    setp(2, 1, 5, 0);
    @(negedge clk);
    check("f_rdy2", in_ready, 5'b00100);
    push(2, 5, 0);
    step();
    reset = 1'b1;
    setp(0, 1, 3, 1);
    @(negedge clk);
    check("f_rst_rdy", in_ready, 0);
    step();
    reset = 1'b0;
    check("f_post_rst_valid", out_valid, 0);
    @(negedge clk);
    check("f_rdy0", in_ready, 5'b00001);
    push(0, 3, 1);
    step();
    check("f_src0", out_src, 0);
    clr();
    step();
    step();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
